// File: rtl/posit_add_arbiter.sv
// ============================================================================
// Module   : posit_add_arbiter
// Purpose  : Shares one posit adder between NREQ requesters. Requests are
//            granted round-robin; the winner's operands are registered into
//            the adder, and the winner's ID follows the operation through a
//            tag pipeline. Each result is held in that requester's slot until
//            the requester accepts it.
// Ports    : clk, reset          - clock, synchronous active-high reset
//            req_valid/ready/a/b - per-requester operation request channel
//            res_valid/ready     - per-requester result slot handshake
//            res_data/inf/zero   - per-slot result payload
//            add_in1/in2/start   - registered issue to the shared adder
//            add_result/inf/zero/done - adder response
//            op_count            - number of accepted operations (wraps)
//            err                 - sticky: add_done disagreed with the tag
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module posit_add_arbiter #(
  parameter int NREQ        = 4,
  parameter int NBITS       = 32,
  parameter int ADD_LATENCY = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*NBITS-1:0] req_a,
  input  logic [NREQ*NBITS-1:0] req_b,
  output logic [NREQ-1:0]       res_valid,
  input  logic [NREQ-1:0]       res_ready,
  output logic [NREQ*NBITS-1:0] res_data,
  output logic [NREQ-1:0]       res_inf,
  output logic [NREQ-1:0]       res_zero,
  output logic [NBITS-1:0]      add_in1,
  output logic [NBITS-1:0]      add_in2,
  output logic                  add_start,
  input  logic [NBITS-1:0]      add_result,
  input  logic                  add_inf,
  input  logic                  add_zero,
  input  logic                  add_done,
  output logic [31:0]           op_count,
  output logic                  err
);

  localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int NSTG = ADD_LATENCY + 1;

  typedef enum logic [1:0] {
    SLOT_IDLE = 2'd0,
    SLOT_BUSY = 2'd1,
    SLOT_FULL = 2'd2
  } slot_state_t;

  logic [NREQ-1:0] slot_idle;
  logic [NREQ-1:0] eligible;
  logic [NREQ-1:0] grant;
  logic            grant_any;
  logic [IDW-1:0]  grant_id;
  logic [IDW-1:0]  cand;
  logic [IDW-1:0]  rr_ptr;
  logic [NBITS-1:0] sel_a;
  logic [NBITS-1:0] sel_b;

  logic [NSTG-1:0] tag_valid;
  logic [IDW-1:0]  tag_id [NSTG];
  logic            exit_valid;
  logic [IDW-1:0]  exit_id;

  // Eligibility uses registered slot state only, so a slot released this
  // cycle cannot be re-granted until the next one. Reset suppresses grants.
  assign eligible = req_valid & slot_idle & {NREQ{~reset}};

  // Round-robin search starting just after the last winner.
  always_comb begin
    grant_any = 1'b0;
    grant_id  = '0;
    grant     = '0;
    cand      = rr_ptr;
    for (int k = 0; k < NREQ; k++) begin
      if (cand == IDW'(NREQ - 1)) begin
        cand = '0;
      end else begin
        cand = cand + 1'b1;
      end
      if (!grant_any && eligible[cand]) begin
        grant_any = 1'b1;
        grant_id  = cand;
      end
    end
    if (grant_any) begin
      grant[grant_id] = 1'b1;
    end
  end

  assign req_ready = grant;

  // Winner operand mux driven from the one-hot grant.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (grant[k]) begin
        sel_a = req_a[k*NBITS +: NBITS];
        sel_b = req_b[k*NBITS +: NBITS];
      end
    end
  end

  // Issue registers, round-robin pointer and operation counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      add_in1   <= '0;
      add_in2   <= '0;
      add_start <= 1'b0;
      op_count  <= '0;
      rr_ptr    <= IDW'(NREQ - 1);
    end else begin
      add_start <= grant_any;
      if (grant_any) begin
        add_in1  <= sel_a;
        add_in2  <= sel_b;
        op_count <= op_count + 32'd1;
        rr_ptr   <= grant_id;
      end
    end
  end

  // Tag pipeline: stage 0 is loaded alongside add_in1/add_in2, so the last
  // stage is valid exactly in the cycle the adder result is valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      tag_valid <= '0;
      for (int s = 0; s < NSTG; s++) begin
        tag_id[s] <= '0;
      end
    end else begin
      tag_valid[0] <= grant_any;
      tag_id[0]    <= grant_id;
      for (int s = 1; s < NSTG; s++) begin
        tag_valid[s] <= tag_valid[s-1];
        tag_id[s]    <= tag_id[s-1];
      end
    end
  end

  assign exit_valid = tag_valid[NSTG-1];
  assign exit_id    = tag_id[NSTG-1];

  // Sticky protocol check between the adder and the tag pipeline.
  always_ff @(posedge clk) begin
    if (reset) begin
      err <= 1'b0;
    end else if (add_done != exit_valid) begin
      err <= 1'b1;
    end
  end

  // Per-requester result slots.
  for (genvar i = 0; i < NREQ; i++) begin : g_slot
    slot_state_t      state;
    logic [NBITS-1:0] data;
    logic             inf;
    logic             zero;
    logic             capture;

    assign capture = exit_valid && (exit_id == IDW'(i));

    always_ff @(posedge clk) begin
      if (reset) begin
        state <= SLOT_IDLE;
        data  <= '0;
        inf   <= 1'b0;
        zero  <= 1'b0;
      end else begin
        case (state)
          SLOT_IDLE: begin
            if (grant[i]) begin
              state <= SLOT_BUSY;
            end
          end
          SLOT_BUSY: begin
            if (capture) begin
              state <= SLOT_FULL;
              data  <= add_result;
              inf   <= add_inf;
              zero  <= add_zero;
            end
          end
          SLOT_FULL: begin
            if (res_ready[i]) begin
              state <= SLOT_IDLE;
            end
          end
          default: state <= SLOT_IDLE;
        endcase
      end
    end

    assign slot_idle[i]                = (state == SLOT_IDLE);
    assign res_valid[i]                = (state == SLOT_FULL);
    assign res_data[i*NBITS +: NBITS]  = data;
    assign res_inf[i]                  = inf;
    assign res_zero[i]                 = zero;
  end

endmodule

`default_nettype wire

// File: tb/tb_posit_add_arbiter.sv
// ============================================================================
// Module   : tb_posit_add_arbiter
// Purpose  : Self-checking bench for posit_add_arbiter. Two instances are
//            driven side by side: one with a combinational stand-in adder
//            (ADD_LATENCY=0) and one with a 3-cycle stand-in adder
//            (ADD_LATENCY=3). A transaction-level model tracks outstanding
//            operations per requester and predicts grants, result timing and
//            slot contents.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_posit_add_arbiter;

  localparam int NREQ  = 4;
  localparam int NBITS = 32;

  logic        clk;
  logic        rst        [2];
  logic [3:0]  req_valid  [2];
  logic [3:0]  req_ready  [2];
  logic [127:0] req_a     [2];
  logic [127:0] req_b     [2];
  logic [3:0]  res_valid  [2];
  logic [3:0]  res_ready  [2];
  logic [127:0] res_data  [2];
  logic [3:0]  res_inf    [2];
  logic [3:0]  res_zero   [2];
  logic [31:0] add_in1    [2];
  logic [31:0] add_in2    [2];
  logic        add_start  [2];
  logic [31:0] add_result [2];
  logic        add_inf    [2];
  logic        add_zero   [2];
  logic        add_done   [2];
  logic [31:0] op_count   [2];
  logic        err        [2];
  logic        force_low;

  posit_add_arbiter #(.NREQ(NREQ), .NBITS(NBITS), .ADD_LATENCY(0)) u_dut0 (
    .clk(clk), .reset(rst[0]),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_a(req_a[0]), .req_b(req_b[0]),
    .res_valid(res_valid[0]), .res_ready(res_ready[0]),
    .res_data(res_data[0]), .res_inf(res_inf[0]), .res_zero(res_zero[0]),
    .add_in1(add_in1[0]), .add_in2(add_in2[0]), .add_start(add_start[0]),
    .add_result(add_result[0]), .add_inf(add_inf[0]), .add_zero(add_zero[0]),
    .add_done(add_done[0]), .op_count(op_count[0]), .err(err[0])
  );

  posit_add_arbiter #(.NREQ(NREQ), .NBITS(NBITS), .ADD_LATENCY(3)) u_dut1 (
    .clk(clk), .reset(rst[1]),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_a(req_a[1]), .req_b(req_b[1]),
    .res_valid(res_valid[1]), .res_ready(res_ready[1]),
    .res_data(res_data[1]), .res_inf(res_inf[1]), .res_zero(res_zero[1]),
    .add_in1(add_in1[1]), .add_in2(add_in2[1]), .add_start(add_start[1]),
    .add_result(add_result[1]), .add_inf(add_inf[1]), .add_zero(add_zero[1]),
    .add_done(add_done[1]), .op_count(op_count[1]), .err(err[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Stand-in adder: exact for the posit cases exercised directly
  // (1+1, 0+0, NaR+x); any other pair just yields a + b so routing is visible.
  function automatic logic [33:0] stub_add(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] s;
    if (a == 32'h8000_0000 || b == 32'h8000_0000) return {2'b10, 32'h8000_0000};
    if (a == 32'h4000_0000 && b == 32'h4000_0000) s = 32'h4800_0000;
    else s = a + b;
    return {1'b0, (s == 32'd0), s};
  endfunction

  // Combinational adder for instance 0.
  logic [33:0] sum0;
  always_comb sum0 = stub_add(add_in1[0], add_in2[0]);
  assign add_done[0]   = add_start[0];
  assign add_inf[0]    = sum0[33];
  assign add_zero[0]   = sum0[32];
  assign add_result[0] = sum0[31:0];

  // Three-stage adder for instance 1, sharing that instance's reset.
  logic [2:0]  p_start;
  logic [31:0] p_a [3];
  logic [31:0] p_b [3];
  logic [33:0] sum1;
  always @(posedge clk) begin
    if (rst[1]) begin
      p_start <= '0;
      for (int s = 0; s < 3; s++) begin
        p_a[s] <= '0;
        p_b[s] <= '0;
      end
    end else begin
      p_start <= {p_start[1:0], add_start[1]};
      p_a[0] <= add_in1[1];
      p_b[0] <= add_in2[1];
      for (int s = 1; s < 3; s++) begin
        p_a[s] <= p_a[s-1];
        p_b[s] <= p_b[s-1];
      end
    end
  end
  always_comb sum1 = stub_add(p_a[2], p_b[2]);
  assign add_done[1]   = p_start[2] & ~force_low;
  assign add_inf[1]    = sum1[33];
  assign add_zero[1]   = sum1[32];
  assign add_result[1] = sum1[31:0];

  // ---------------------------------------------------------------------
  // Reference model state
  // ---------------------------------------------------------------------
  int          checks;
  int          errors;
  int          cyc;
  int          lat      [2];
  int          last_win [2];
  int          win_n    [2];
  logic [3:0]  outst    [2];
  int          gcyc     [2][4];
  logic [33:0] pend     [2][4];
  logic [33:0] shown    [2][4];
  logic [31:0] last_a   [2];
  logic [31:0] last_b   [2];
  logic [31:0] win_a    [2];
  logic [31:0] win_b    [2];
  logic        exp_start[2];
  logic [31:0] exp_cnt  [2];
  logic        exp_err  [2];
  logic [3:0]  hs       [2];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset(input int d);
    last_win[d]  = NREQ - 1;
    outst[d]     = '0;
    last_a[d]    = '0;
    last_b[d]    = '0;
    exp_start[d] = 1'b0;
    exp_cnt[d]   = '0;
    exp_err[d]   = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      gcyc[d][i]  = 0;
      pend[d][i]  = '0;
      shown[d][i] = '0;
    end
  endtask

  // Mid-cycle comparison of every observable against the model.
  task automatic check_dut(input int d);
    logic [3:0]   elig;
    logic [3:0]   exp_rdy;
    logic [3:0]   exp_rv;
    logic [127:0] exp_d;
    logic [3:0]   exp_i;
    logic [3:0]   exp_z;
    int           idx;
    win_n[d] = -1;
    exp_rdy  = '0;
    if (!rst[d]) begin
      elig = req_valid[d] & ~outst[d];
      for (int k = 1; k <= NREQ; k++) begin
        idx = (last_win[d] + k) % NREQ;
        if (win_n[d] < 0 && elig[idx]) win_n[d] = idx;
      end
    end
    if (win_n[d] >= 0) begin
      exp_rdy[win_n[d]] = 1'b1;
      win_a[d] = req_a[d][win_n[d]*32 +: 32];
      win_b[d] = req_b[d][win_n[d]*32 +: 32];
    end
    for (int i = 0; i < NREQ; i++) begin
      exp_rv[i]          = outst[d][i] && (cyc >= gcyc[d][i] + 2 + lat[d]);
      exp_d[i*32 +: 32]  = shown[d][i][31:0];
      exp_z[i]           = shown[d][i][32];
      exp_i[i]           = shown[d][i][33];
    end
    chk($sformatf("d%0d.req_ready@%0d", d, cyc), 128'(req_ready[d]), 128'(exp_rdy));
    chk($sformatf("d%0d.res_valid@%0d", d, cyc), 128'(res_valid[d]), 128'(exp_rv));
    chk($sformatf("d%0d.res_data@%0d", d, cyc), res_data[d], exp_d);
    chk($sformatf("d%0d.res_flags@%0d", d, cyc), 128'({res_inf[d], res_zero[d]}), 128'({exp_i, exp_z}));
    chk($sformatf("d%0d.add_start@%0d", d, cyc), 128'(add_start[d]), 128'(exp_start[d]));
    chk($sformatf("d%0d.add_in@%0d", d, cyc), 128'({add_in1[d], add_in2[d]}), 128'({last_a[d], last_b[d]}));
    chk($sformatf("d%0d.op_count@%0d", d, cyc), 128'(op_count[d]), 128'(exp_cnt[d]));
    chk($sformatf("d%0d.err@%0d", d, cyc), 128'(err[d]), 128'(exp_err[d]));
    hs[d] = res_valid[d] & res_ready[d];
  endtask

  // Advance the model across the clock edge that ends the current cycle.
  task automatic model_update(input int d);
    int w;
    if (rst[d]) begin
      model_reset(d);
      return;
    end
    for (int i = 0; i < NREQ; i++) begin
      if (outst[d][i] && cyc == gcyc[d][i] + 1 + lat[d]) begin
        shown[d][i] = pend[d][i];
        if (d == 1 && force_low) exp_err[d] = 1'b1;
      end
      if (hs[d][i]) outst[d][i] = 1'b0;
    end
    w = win_n[d];
    exp_start[d] = (w >= 0);
    if (w >= 0) begin
      outst[d][w]  = 1'b1;
      gcyc[d][w]   = cyc;
      pend[d][w]   = stub_add(win_a[d], win_b[d]);
      last_a[d]    = win_a[d];
      last_b[d]    = win_b[d];
      last_win[d]  = w;
      exp_cnt[d]   = exp_cnt[d] + 32'd1;
    end
  endtask

  task automatic step();
    @(negedge clk);
    for (int d = 0; d < 2; d++) check_dut(d);
    @(posedge clk);
    for (int d = 0; d < 2; d++) model_update(d);
    cyc++;
    #1;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h4000_0000;
      2: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  task automatic rand_ops(input int d);
    for (int i = 0; i < NREQ; i++) begin
      req_a[d][i*32 +: 32] = pick();
      req_b[d][i*32 +: 32] = pick();
    end
  endtask

  function automatic bit exit_pending(input int d);
    for (int i = 0; i < NREQ; i++)
      if (outst[d][i] && cyc == gcyc[d][i] + 1 + lat[d]) return 1'b1;
    return 1'b0;
  endfunction

  // ---------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------
  initial begin
    bit found;
    checks = 0;
    errors = 0;
    cyc    = 0;
    lat[0] = 0;
    lat[1] = 3;
    force_low = 1'b0;
    for (int d = 0; d < 2; d++) begin
      model_reset(d);
      rst[d]       = 1'b1;
      req_valid[d] = '0;
      res_ready[d] = 4'hF;
      req_a[d]     = '0;
      req_b[d]     = '0;
      hs[d]        = '0;
      win_n[d]     = -1;
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    step();                                  // reset values checked by model
    rst[0] = 1'b0;
    rst[1] = 1'b0;

    // Single op: 1.0 + 1.0 on requester 0, result held for inspection.
    req_a[0][31:0] = 32'h4000_0000;
    req_b[0][31:0] = 32'h4000_0000;
    req_valid[0]   = 4'b0001;
    res_ready[0]   = 4'b0000;
    step();
    req_valid[0] = '0;
    chk("single.add_start", 128'(add_start[0]), 128'(1'b1));
    chk("single.add_in1", 128'(add_in1[0]), 128'(32'h4000_0000));
    step();
    chk("single.res_valid", 128'(res_valid[0]), 128'(4'b0001));
    chk("single.res_data", 128'(res_data[0][31:0]), 128'(32'h4800_0000));
    chk("single.op_count", 128'(op_count[0]), 128'(32'd1));
    res_ready[0] = 4'hF;
    step();

    // All requesters valid continuously on both instances.
    req_valid[0] = 4'hF;
    req_valid[1] = 4'hF;
    repeat (24) begin
      rand_ops(0);
      rand_ops(1);
      step();
    end

    // Backpressure on slot 2 of both instances.
    res_ready[0] = 4'b1011;
    res_ready[1] = 4'b1011;
    repeat (16) begin
      rand_ops(0);
      rand_ops(1);
      step();
    end
    chk("bp.slot2_held0", 128'(res_valid[0][2]), 128'(1'b1));
    chk("bp.slot2_held1", 128'(res_valid[1][2]), 128'(1'b1));
    res_ready[0] = 4'hF;
    res_ready[1] = 4'hF;
    repeat (8) begin
      rand_ops(0);
      rand_ops(1);
      step();
    end
    req_valid[0] = '0;
    req_valid[1] = '0;
    repeat (6) step();

    // Special values: zero + zero and NaR + one.
    req_a[0][31:0]  = 32'h0000_0000;
    req_b[0][31:0]  = 32'h0000_0000;
    req_a[0][63:32] = 32'h8000_0000;
    req_b[0][63:32] = 32'h4000_0000;
    res_ready[0]    = 4'b0000;
    req_valid[0]    = 4'b0011;
    step();
    step();
    req_valid[0] = '0;
    step();
    step();
    chk("special.zero_flag", 128'(res_zero[0][0]), 128'(1'b1));
    chk("special.zero_data", 128'(res_data[0][31:0]), 128'(32'h0));
    chk("special.inf_flag", 128'(res_inf[0][1]), 128'(1'b1));
    chk("special.inf_data", 128'(res_data[0][63:32]), 128'(32'h8000_0000));
    res_ready[0] = 4'hF;
    step();
    step();

    // Latency 3: interleave requesters 1 and 3.
    req_valid[1] = 4'b1010;
    repeat (20) begin
      rand_ops(1);
      step();
    end
    chk("lat3.err_clear", 128'(err[1]), 128'(1'b0));
    found = 1'b0;
    for (int n = 0; n < 20 && !found; n++) begin
      if (exit_pending(1)) found = 1'b1;
      else step();
    end
    chk("lat3.force_window", 128'(found), 128'(1'b1));
    force_low = 1'b1;
    step();
    force_low = 1'b0;
    repeat (6) step();
    chk("lat3.err_sticky", 128'(err[1]), 128'(1'b1));

    // Reset with two operations in flight on the latency-3 instance.
    rand_ops(1);
    step();
    step();
    rst[1]       = 1'b1;
    req_valid[1] = '0;
    step();
    rst[1] = 1'b0;
    chk("rst.res_valid", 128'(res_valid[1]), 128'(4'b0));
    chk("rst.add_start", 128'(add_start[1]), 128'(1'b0));
    chk("rst.op_count", 128'(op_count[1]), 128'(32'd0));
    chk("rst.err", 128'(err[1]), 128'(1'b0));
    chk("rst.res_data", res_data[1], 128'(0));
    chk("rst.add_in", 128'({add_in1[1], add_in2[1]}), 128'(0));
    repeat (8) step();
    chk("rst.no_late_result", 128'(res_valid[1]), 128'(4'b0));
    req_valid[1] = 4'hF;
    rand_ops(1);
    #1;
    chk("rst.first_grant", 128'(req_ready[1]), 128'(4'b0001));
    repeat (10) begin
      step();
      rand_ops(1);
    end
    req_valid[1] = '0;
    repeat (8) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
